// File: rtl/cgra_alu_pkg.sv
// cgra_alu_pkg: shared definitions for the CGRA PE ALU pipeline.
//   opcode_t   : 4-bit operation select
//   OP_*       : opcode encodings
//   ALU_LAT    : fixed result latency in enabled cycles
//   is_mul_op  : true for ops whose result comes from the multiplier path
package cgra_alu_pkg;

    localparam int ALU_LAT = 3;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP    = 4'h0;
    localparam opcode_t OP_MULADD = 4'h1;
    localparam opcode_t OP_MULSUB = 4'h2;
    localparam opcode_t OP_ADDADD = 4'h3;
    localparam opcode_t OP_ADDSUB = 4'h4;
    localparam opcode_t OP_SUBSUB = 4'h5;
    localparam opcode_t OP_PHI    = 4'h6;
    localparam opcode_t OP_RSFAND = 4'h7;
    localparam opcode_t OP_LSFADD = 4'h8;
    localparam opcode_t OP_ABS    = 4'h9;
    localparam opcode_t OP_GT     = 4'hA;
    localparam opcode_t OP_LET    = 4'hB;
    localparam opcode_t OP_ANDAND = 4'hC;
    localparam opcode_t OP_MIN    = 4'hD;
    localparam opcode_t OP_MAX    = 4'hE;
    localparam opcode_t OP_ORXOR  = 4'hF;

    function automatic logic is_mul_op(input opcode_t op);
        return (op == OP_MULADD) || (op == OP_MULSUB);
    endfunction

endpackage

// File: rtl/cgra_mul_pipe.sv
// cgra_mul_pipe: 2-stage unsigned MUL_WIDTH x MUL_WIDTH multiply, then +/- In2.
//   Clk, Resetn : clock, async active-low reset
//   En          : advance; 0 holds both stages
//   In0, In1    : multiplier operands (MUL_WIDTH)
//   In2         : addend / subtrahend (DWIDTH)
//   Sub         : 1 = product - In2, 0 = product + In2
//   Res         : DWIDTH result, registered in the second stage
// Fed from the ALU's S0 registers, so Res lines up with the ALU's S2 stage.
module cgra_mul_pipe #(
    parameter int DWIDTH    = 32,
    parameter int MUL_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Resetn,
    input  logic                 En,
    input  logic [MUL_WIDTH-1:0] In0,
    input  logic [MUL_WIDTH-1:0] In1,
    input  logic [DWIDTH-1:0]    In2,
    input  logic                 Sub,
    output logic [DWIDTH-1:0]    Res
);

    logic [2*MUL_WIDTH-1:0] prod_full;
    logic [DWIDTH-1:0]      prod_q;
    logic [DWIDTH-1:0]      c_q;
    logic                   sub_q;

    // Widen before multiplying so the full 2*MW product is kept; the
    // DWIDTH cast then zero-extends or truncates as needed.
    assign prod_full = (2*MUL_WIDTH)'(In0) * (2*MUL_WIDTH)'(In1);

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            prod_q <= '0;
            c_q    <= '0;
            sub_q  <= 1'b0;
            Res    <= '0;
        end else if (En) begin
            prod_q <= DWIDTH'(prod_full);
            c_q    <= In2;
            sub_q  <= Sub;
            Res    <= sub_q ? (prod_q - c_q) : (prod_q + c_q);
        end
    end

endmodule

// File: rtl/cgra_alu_pipe.sv
// cgra_alu_pipe: fixed-latency (ALU_LAT=3) three-operand ALU for the CGRA PE.
//   Clk, Resetn        : clock, async active-low reset
//   En                 : pipeline advance; 0 holds every register
//   Flush              : sync clear of all in-flight valids (only with En=1)
//   In_Valid, Opcode   : operand-set valid and operation select
//   ALU_In0/1/2        : operands (DWIDTH)
//   Out_Valid, ALU_Out : registered result and its valid
// Stages: S0 operand regs -> S1 first-level op -> S2 second op with In2
// (multiplier result joins here) -> output register.
module cgra_alu_pipe
    import cgra_alu_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int MUL_WIDTH = 16
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic              En,
    input  logic              Flush,
    input  logic              In_Valid,
    input  logic [3:0]        Opcode,
    input  logic [DWIDTH-1:0] ALU_In0,
    input  logic [DWIDTH-1:0] ALU_In1,
    input  logic [DWIDTH-1:0] ALU_In2,
    output logic              Out_Valid,
    output logic [DWIDTH-1:0] ALU_Out
);

    localparam int SHW = $clog2(DWIDTH);

    typedef logic [DWIDTH-1:0] word_t;

    logic [ALU_LAT:0] vld_pipe;
    opcode_t          op0, op1, op2;
    word_t            a0, b0, c0;
    word_t            x1, c1;
    word_t            alu2, mul2;
    word_t            x1_d, alu_d, addsub;
    logic [SHW-1:0]   sh;

    // Log-depth barrel shifters: stage k shifts by 2^k when sh[k] is set.
    word_t shl_st [SHW+1];
    word_t shr_st [SHW+1];

    assign sh        = b0[SHW-1:0];
    assign shl_st[0] = a0;
    assign shr_st[0] = a0;

    for (genvar k = 0; k < SHW; k++) begin : g_sh
        assign shl_st[k+1] = sh[k] ? (shl_st[k] << (1 << k)) : shl_st[k];
        assign shr_st[k+1] = sh[k] ? (shr_st[k] >> (1 << k)) : shr_st[k];
    end

    // S1: first-level result. PHI resolves fully here since it needs only
    // a compare and a select; MUL ops bypass this path.
    always_comb begin
        x1_d = '0;
        unique case (op0)
            OP_ADDADD, OP_ADDSUB: x1_d = a0 + b0;
            OP_SUBSUB:            x1_d = a0 - b0;
            OP_PHI:               x1_d = (a0 != '0) ? b0 : c0;
            OP_RSFAND:            x1_d = shr_st[SHW];
            OP_LSFADD:            x1_d = shl_st[SHW];
            OP_ABS:               x1_d = a0[DWIDTH-1] ? (word_t'(0) - a0) : a0;
            OP_GT:                x1_d = word_t'(a0 > b0);
            OP_LET:               x1_d = word_t'(a0 <= b0);
            OP_ANDAND:            x1_d = a0 & b0;
            OP_MIN:               x1_d = (a0 < b0) ? a0 : b0;
            OP_MAX:               x1_d = (a0 > b0) ? a0 : b0;
            OP_ORXOR:             x1_d = a0 | b0;
            default:              x1_d = '0;
        endcase
    end

    // S2: one shared adder/subtractor serves every "+/- In2" op.
    assign addsub = ((op1 == OP_ADDSUB) || (op1 == OP_SUBSUB)) ? (x1 - c1) : (x1 + c1);

    always_comb begin
        alu_d = '0;
        unique case (op1)
            OP_ADDADD, OP_ADDSUB, OP_SUBSUB, OP_LSFADD: alu_d = addsub;
            OP_RSFAND, OP_ANDAND:                       alu_d = x1 & c1;
            OP_ORXOR:                                   alu_d = x1 ^ c1;
            OP_PHI, OP_ABS, OP_GT, OP_LET, OP_MIN, OP_MAX: alu_d = x1;
            default:                                    alu_d = '0;
        endcase
    end

    cgra_mul_pipe #(
        .DWIDTH    (DWIDTH),
        .MUL_WIDTH (MUL_WIDTH)
    ) u_mul (
        .Clk    (Clk),
        .Resetn (Resetn),
        .En     (En),
        .In0    (a0[MUL_WIDTH-1:0]),
        .In1    (b0[MUL_WIDTH-1:0]),
        .In2    (c0),
        .Sub    (op0 == OP_MULSUB),
        .Res    (mul2)
    );

    // Operand/data registers move with En regardless of Flush; only the
    // valid/opcode tags and the visible output are cleared. A cleared
    // opcode (NOP) forces a zero result downstream, so stale data never
    // reaches ALU_Out.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            vld_pipe <= '0;
            op0      <= OP_NOP;
            op1      <= OP_NOP;
            op2      <= OP_NOP;
            a0       <= '0;
            b0       <= '0;
            c0       <= '0;
            x1       <= '0;
            c1       <= '0;
            alu2     <= '0;
            ALU_Out  <= '0;
        end else if (En) begin
            a0 <= ALU_In0;
            b0 <= ALU_In1;
            c0 <= ALU_In2;
            x1 <= x1_d;
            c1 <= c0;
            if (Flush) begin
                vld_pipe <= '0;
                op0      <= OP_NOP;
                op1      <= OP_NOP;
                op2      <= OP_NOP;
                alu2     <= '0;
                ALU_Out  <= '0;
            end else begin
                vld_pipe <= {vld_pipe[ALU_LAT-1:0], In_Valid};
                op0      <= In_Valid ? opcode_t'(Opcode) : OP_NOP;
                op1      <= op0;
                op2      <= op1;
                alu2     <= alu_d;
                ALU_Out  <= is_mul_op(op2) ? mul2 : alu2;
            end
        end
    end

    assign Out_Valid = vld_pipe[ALU_LAT];

endmodule

// File: tb/tb_cgra_alu_pipe.sv
// Directed self-checking bench for cgra_alu_pipe: a 32/16 build and a
// 16/8 build share clock, reset, En and Flush.
module tb_cgra_alu_pipe;
    import cgra_alu_pkg::*;

    logic        Clk = 1'b0;
    logic        Resetn;
    logic        en, flush;
    logic        iv, iv16;
    logic [3:0]  op, op16;
    logic [31:0] i0, i1, i2, out32;
    logic [15:0] j0, j1, j2, out16;
    logic        ov, ov16;

    int total = 0;
    int bad   = 0;

    opcode_t     t_op [20];
    logic [31:0] t_a [20], t_b [20], t_c [20], t_e [20];

    always #5 Clk = ~Clk;

    cgra_alu_pipe #(.DWIDTH(32), .MUL_WIDTH(16)) dut32 (
        .Clk(Clk), .Resetn(Resetn), .En(en), .Flush(flush), .In_Valid(iv),
        .Opcode(op), .ALU_In0(i0), .ALU_In1(i1), .ALU_In2(i2),
        .Out_Valid(ov), .ALU_Out(out32));

    cgra_alu_pipe #(.DWIDTH(16), .MUL_WIDTH(8)) dut16 (
        .Clk(Clk), .Resetn(Resetn), .En(en), .Flush(flush), .In_Valid(iv16),
        .Opcode(op16), .ALU_In0(j0), .ALU_In1(j1), .ALU_In2(j2),
        .Out_Valid(ov16), .ALU_Out(out16));

    // Invalid slots carry junk so that bubble forcing is exercised.
    task automatic idle_all();
        iv = 1'b0; op = OP_MULADD; i0 = 32'h1234_5678; i1 = 32'h9; i2 = 32'hABCD;
        iv16 = 1'b0; op16 = OP_ADDADD; j0 = 16'h1234; j1 = 16'h9; j2 = 16'hABCD;
    endtask

    task automatic drive(input bit w16, input opcode_t o, input logic [31:0] a, b, c);
        idle_all();
        if (w16) begin
            iv16 = 1'b1; op16 = o; j0 = a[15:0]; j1 = b[15:0]; j2 = c[15:0];
        end else begin
            iv = 1'b1; op = o; i0 = a; i1 = b; i2 = c;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input bit w16, input string tag, input logic v, input logic [31:0] d);
        logic        v_o;
        logic [31:0] d_o, d_x;
        v_o = w16 ? ov16 : ov;
        d_o = w16 ? {16'h0, out16} : out32;
        d_x = w16 ? {16'h0, d[15:0]} : d;
        total++;
        assert (v_o === v) else begin
            bad++;
            $error("FAIL %s w16=%0b Out_Valid observed=%b expected=%b", tag, w16, v_o, v);
        end
        total++;
        assert (d_o === d_x) else begin
            bad++;
            $error("FAIL %s w16=%0b ALU_Out observed=%h expected=%h", tag, w16, d_o, d_x);
        end
    endtask

    task automatic setv(input int k, input opcode_t o, input logic [31:0] a, b, c, e);
        t_op[k] = o; t_a[k] = a; t_b[k] = b; t_c[k] = c; t_e[k] = e;
    endtask

    // Back-to-back issue of t_*[0..n-1] into a drained pipe; each result
    // must appear exactly 3 edges after issue, then one idle output.
    task automatic run_stream(input bit w16, input string tag, input int n);
        for (int k = 0; k < n + 3; k++) begin
            if (k < n) drive(w16, t_op[k], t_a[k], t_b[k], t_c[k]);
            else       idle_all();
            step();
            if (k >= 3) chk(w16, tag, 1'b1, t_e[k-3]);
            else        chk(w16, tag, 1'b0, 32'h0);
        end
        idle_all();
        step();
        chk(w16, {tag, "_tail"}, 1'b0, 32'h0);
    endtask

    initial begin
        Resetn = 1'b0; en = 1'b1; flush = 1'b0;
        idle_all();
        #12;
        chk(0, "reset", 1'b0, 32'h0);
        chk(1, "reset", 1'b0, 32'h0);
        Resetn = 1'b1;

        // Single MULADD, latency 3, valid for one cycle
        setv(0, OP_MULADD, 32'h0001_0003, 32'd7, 32'd5, 32'd26);
        run_stream(0, "muladd", 1);

        // Mixed MUL / ALU stream
        setv(0, OP_SUBSUB, 32'd10, 32'd3, 32'd9, 32'hFFFF_FFFE);
        setv(1, OP_MULADD, 32'd3, 32'd4, 32'd1, 32'd13);
        setv(2, OP_LSFADD, 32'hFF, 32'd36, 32'd1, 32'hFF1);
        setv(3, OP_MULSUB, 32'd2, 32'd3, 32'd7, 32'hFFFF_FFFF);
        setv(4, OP_RSFAND, 32'h8000_0000, 32'd31, 32'hF, 32'd1);
        setv(5, OP_MULADD, 32'h0001_2345, 32'h0001_0002, 32'd0, 32'h468A);
        setv(6, OP_MULSUB, 32'hFFFF, 32'hFFFF, 32'd1, 32'hFFFE_0000);
        setv(7, OP_ADDADD, 32'd1, 32'd2, 32'd3, 32'd6);
        run_stream(0, "stream", 8);

        // Boundary and remaining opcodes
        setv(0,  OP_GT,     32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
        setv(1,  OP_GT,     32'd1, 32'd2, 32'd0, 32'd0);
        setv(2,  OP_LET,    32'd5, 32'd5, 32'd0, 32'd1);
        setv(3,  OP_LET,    32'd6, 32'd5, 32'd0, 32'd0);
        setv(4,  OP_ABS,    32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000);
        setv(5,  OP_ABS,    32'hFFFF_FFFB, 32'd0, 32'd0, 32'd5);
        setv(6,  OP_ABS,    32'd7, 32'd0, 32'd0, 32'd7);
        setv(7,  OP_PHI,    32'd0, 32'd11, 32'd22, 32'd22);
        setv(8,  OP_PHI,    32'd1, 32'd11, 32'd22, 32'd11);
        setv(9,  OP_MIN,    32'd3, 32'hFFFF_FFFF, 32'd0, 32'd3);
        setv(10, OP_MAX,    32'd3, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
        setv(11, OP_ANDAND, 32'hFF, 32'h0F, 32'h3C, 32'h0C);
        setv(12, OP_ORXOR,  32'hF0, 32'h0F, 32'hFF, 32'h0);
        setv(13, OP_ADDSUB, 32'd10, 32'd5, 32'd20, 32'hFFFF_FFFB);
        setv(14, OP_NOP,    32'd5, 32'd6, 32'd7, 32'h0);
        setv(15, OP_RSFAND, 32'hF0, 32'hFFFF_FF24, 32'hFF, 32'h0F);
        setv(16, OP_LSFADD, 32'd1, 32'd31, 32'd0, 32'h8000_0000);
        run_stream(0, "edge", 17);

        // Stall: En low for 2 cycles while a result is on the output
        drive(0, OP_ADDADD, 32'd1, 32'd1, 32'd1);   step();
        drive(0, OP_MAX, 32'd7, 32'd9, 32'd0);      step();
        drive(0, OP_MULADD, 32'd5, 32'd5, 32'd0);   step();
        drive(0, OP_ORXOR, 32'd1, 32'd2, 32'd4);    step();
        chk(0, "stall_a", 1'b1, 32'd3);
        en = 1'b0;
        drive(0, OP_ADDADD, 32'd100, 32'd100, 32'd100);
        step(); chk(0, "stall_hold1", 1'b1, 32'd3);
        step(); chk(0, "stall_hold2", 1'b1, 32'd3);
        en = 1'b1;
        idle_all();
        step(); chk(0, "stall_b", 1'b1, 32'd9);
        step(); chk(0, "stall_c", 1'b1, 32'd25);
        step(); chk(0, "stall_d", 1'b1, 32'd7);
        step(); chk(0, "stall_end1", 1'b0, 32'h0);
        step(); chk(0, "stall_end2", 1'b0, 32'h0);

        // Flush with 3 ops in flight; same-cycle input discarded
        drive(0, OP_ADDADD, 32'd1, 32'd2, 32'd3);   step();
        drive(0, OP_MULADD, 32'd2, 32'd2, 32'd2);   step();
        drive(0, OP_MAX, 32'd4, 32'd8, 32'd0);      step();
        flush = 1'b1;
        drive(0, OP_ADDADD, 32'd9, 32'd9, 32'd9);   step();
        flush = 1'b0;
        chk(0, "flush_now", 1'b0, 32'h0);
        idle_all();
        for (int k = 0; k < 4; k++) begin
            step(); chk(0, "flush_gone", 1'b0, 32'h0);
        end

        // Flush while stalled is ignored
        drive(0, OP_ADDADD, 32'd2, 32'd2, 32'd2);   step();
        en = 1'b0; flush = 1'b1;
        drive(0, OP_MAX, 32'd50, 32'd60, 32'd0);    step();
        chk(0, "flushoff_1", 1'b0, 32'h0);
        en = 1'b1; flush = 1'b0;
        idle_all();
        step(); chk(0, "flushoff_2", 1'b0, 32'h0);
        step(); chk(0, "flushoff_3", 1'b0, 32'h0);
        step(); chk(0, "flushoff_res", 1'b1, 32'd6);
        step(); chk(0, "flushoff_end", 1'b0, 32'h0);

        // Async reset between edges with 3 ops in flight
        drive(0, OP_ADDADD, 32'd1, 32'd1, 32'd1);   step();
        drive(0, OP_MULADD, 32'd3, 32'd3, 32'd0);   step();
        drive(0, OP_MIN, 32'd4, 32'd5, 32'd0);      step();
        drive(0, OP_ORXOR, 32'd8, 32'd0, 32'd0);    step();
        chk(0, "prerst", 1'b1, 32'd3);
        idle_all();
        #2 Resetn = 1'b0;
        #1 chk(0, "async_rst", 1'b0, 32'h0);
        #2 Resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(); chk(0, "rst_gone", 1'b0, 32'h0);
        end
        setv(0, OP_SUBSUB, 32'd10, 32'd3, 32'd9, 32'hFFFF_FFFE);
        run_stream(0, "post_rst", 1);

        // 16/8 build: scenarios 1-3 with truncated values
        setv(0, OP_MULADD, 32'h0103, 32'd7, 32'd5, 32'd26);
        run_stream(1, "w16_muladd", 1);

        setv(0, OP_SUBSUB, 32'd10, 32'd3, 32'd9, 32'hFFFE);
        setv(1, OP_MULADD, 32'h1FF, 32'h102, 32'd1, 32'h1FF);
        setv(2, OP_LSFADD, 32'hFF, 32'd36, 32'd1, 32'hFF1);
        setv(3, OP_MULSUB, 32'd2, 32'd3, 32'd7, 32'hFFFF);
        setv(4, OP_RSFAND, 32'h8000, 32'd31, 32'hF, 32'd1);
        setv(5, OP_MULADD, 32'hFF, 32'hFF, 32'd0, 32'hFE01);
        run_stream(1, "w16_stream", 6);

        setv(0, OP_GT,  32'hFFFF, 32'd1, 32'd0, 32'd1);
        setv(1, OP_LET, 32'd5, 32'd5, 32'd0, 32'd1);
        setv(2, OP_ABS, 32'h8000, 32'd0, 32'd0, 32'h8000);
        setv(3, OP_ABS, 32'hFFFB, 32'd0, 32'd0, 32'd5);
        setv(4, OP_PHI, 32'd0, 32'd11, 32'd22, 32'd22);
        setv(5, OP_MIN, 32'd3, 32'hFFFF, 32'd0, 32'd3);
        run_stream(1, "w16_edge", 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cgra_alu_pipe.md
# cgra_alu_pipe

Parametrised, fixed-latency, three-operand ALU for the CGRA processing element. It computes one of 15 fused operations per cycle, including multiply-add, general shifts and compares. Every opcode completes in exactly LAT=3 cycles, so the static scheduler sees a single latency. The block adds valid tagging, a pipeline-wide stall (En) and a synchronous Flush. It sits between the PE operand muxes/register file and the PE output register.

## Interface
Parameters:
- DWIDTH, 32, datapath width; power of two, 8..64
- MUL_WIDTH, 16, multiplier operand width (low bits of In0/In1); 1..DWIDTH
- SHW, $clog2(DWIDTH), derived shift-amount width; not overridable

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Resetn  in  1  reset, asynchronous, active-low
- En  in  1  pipeline advance; 0 = every stage register holds
- Flush  in  1  synchronous; clears all stage valids (applied only when En=1)
- In_Valid  in  1  operand set valid this cycle
- Opcode  in  4  operation select
- ALU_In0 / ALU_In1 / ALU_In2  in  DWIDTH each  operands
- Out_Valid  out  1  ALU_Out carries a result
- ALU_Out  out  DWIDTH  result

## Operation
- All arithmetic is unsigned and modulo 2^DWIDTH. Compares are unsigned. sh = ALU_In1[SHW-1:0]; upper bits of In1 are ignored for shifts.
- Opcode results:
  - 0 NOP → 0
  - 1 MULADD: In0[MW-1:0]*In1[MW-1:0] + In2, with the product zero-extended or truncated to DWIDTH
  - 2 MULSUB: the same product − In2
  - 3 ADDADD: In0+In1+In2
  - 4 ADDSUB: In0+In1−In2
  - 5 SUBSUB: In0−In1−In2
  - 6 PHI: In0≠0 ? In1 : In2
  - 7 RSFAND: (In0>>sh)&In2, logical shift
  - 8 LSFADD: (In0<<sh)+In2
  - 9 ABS: In0[MSB] ? −In0 : In0
  - A GT: In0>In1 → 1, else 0
  - B LET: In0≤In1 → 1, else 0
  - C ANDAND: In0&In1&In2
  - D MIN: min(In0,In1)
  - E MAX: max(In0,In1)
  - F ORXOR: (In0|In1)^In2
- ABS of the most negative value returns that value unchanged.
- Bubbles: an entry with In_Valid=0 is forced to NOP at stage 0, so it yields Out_Valid=0 and ALU_Out=0.
- Reset values: every stage register is 0, Out_Valid=0, ALU_Out=0.

## Timing
- Stages:
  - S0 registers operands, opcode and valid.
  - S1 computes first-level results (product stage 1, In0±In1, shift, AND/OR, compares) and carries In2 forward.
  - S2 applies the second operator with In2, selects by opcode and registers the result into ALU_Out/Out_Valid.
- Latency: an operand set sampled at edge N with En=1 appears at edge N+3, provided En=1 at N+1 and N+2.
- Throughput is one operation per cycle. There are no hazards: operations are independent.
- En=0: all stages, including the multiplier's internal registers, hold. Out_Valid and ALU_Out stay stable. Each En=0 cycle extends latency by exactly one cycle.
- Flush=1 with En=1: at that edge the S0/S1/S2 valids become 0 and ALU_Out becomes 0. Inputs presented in the same cycle are discarded. The next valid input appears 3 enabled edges later.
- Flush=1 with En=0: ignored.
- Asynchronous Resetn mid-stream: all in-flight operations are lost immediately and the outputs go to 0. The first input after deassertion is sampled on the first rising edge with Resetn=1.
- The multiplier path and the ALU path must have identical latency. Opcode switches between MUL and non-MUL ops on back-to-back cycles produce no collisions and no gaps.

## Structure
- Package cgra_alu_pkg holds:
  - opcode localparams OP_NOP..OP_ORXOR
  - the typedef opcode_t (logic [3:0])
  - the constant ALU_LAT = 3, which the scheduler-facing code also uses
- Sub-module cgra_mul_pipe: 2-stage pipelined unsigned MUL_WIDTH×MUL_WIDTH multiplier with an en input. It takes the product plus In2 and a subtract flag, and outputs DWIDTH bits aligned to S2.
- The second-stage add/sub is shared among ADDADD/ADDSUB/SUBSUB/LSFADD. The shifter is a log-depth barrel shifter in S1.

## Test plan
- Reset, then MULADD In0=0x0001_0003, In1=7, In2=5 (MW=16): result 26 three cycles later, Out_Valid 1 for one cycle.
- Back-to-back stream of SUBSUB(10,3,9), LSFADD(0xFF,36,1) and RSFAND(0x8000_0000,31,0xF), with MUL ops interleaved:
  - SUBSUB → 0xFFFF_FFFE
  - LSFADD (sh=4) → 0xFF1
  - RSFAND → 1
  - Results arrive on consecutive cycles in issue order.
- Boundary cases:
  - GT(0xFFFF_FFFF,1) → 1
  - LET(5,5) → 1
  - ABS(0x8000_0000) → 0x8000_0000
  - ABS(0xFFFF_FFFB) → 5
  - PHI(0,11,22) → 22
  - MIN(3,0xFFFF_FFFF) → 3
- Stall: issue 4 ops and drop En for 2 cycles mid-stream. Outputs freeze, then the results resume in order with each latency +2 and nothing lost or duplicated.
- Flush with 3 ops in flight: Out_Valid=0 and ALU_Out=0 on the next edge, and none of the 3 results ever emerges. Flush with En=0 has no effect.
- Assert Resetn low asynchronously between edges with 3 ops in flight: outputs go to 0 immediately. The DWIDTH=16/MW=8 build repeats scenarios 1–3 with truncated values.
